ks16_pipe_subtractor: RTL and testbench

- 16-bit Kogge-Stone subtractor, 3-stage pipeline: diff = a - b - bin, with borrow-out and signed-overflow flags.
- It is the complement of the existing Kogge-Stone adder datapath and reuses the same generate/propagate prefix network.
- Operands enter through a valid/ready handshake and results leave through one. A sideband tag travels with each operation.

---
 rtl/ks_pkg.sv | 21 ++
 rtl/ks_prefix_cell.sv | 14 +
 rtl/ks16_pipe_subtractor.sv | 168 ++++++++++++++++
 tb/tb_ks16_pipe_subtractor.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ks_pkg.sv
// Shared Kogge-Stone definitions for the adder and subtractor datapaths:
// operand width, prefix depth, the per-column (G, P) pair and the leaf cell.
package ks_pkg;

   localparam int WIDTH  = 16;
   localparam int LEVELS = 4;

   typedef struct packed {
      logic g;
      logic p;
   } gp_t;

   // Bit-level generate/propagate for one column of a + b'.
   function automatic gp_t ks_leaf(input logic a, input logic b);
      gp_t r;
      r.g = a & b;
      r.p = a ^ b;
      return r;
   endfunction

endpackage

// File: rtl/ks_prefix_cell.sv
// Black prefix node: merges a high (G, P) group with the adjacent low group.
module ks_prefix_cell (
   input  logic Gh,
   input  logic Ph,
   input  logic Gl,
   input  logic Pl,
   output logic G,
   output logic P
);

   assign G = Gh | (Ph & Gl);
   assign P = Ph & Pl;

endmodule

// File: rtl/ks16_pipe_subtractor.sv
// 16-bit Kogge-Stone subtractor, diff = a - b - bin, three registered stages
// with a bubble-collapsing valid/ready pipeline and a pass-through tag.
module ks16_pipe_subtractor
   import ks_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int TAG_W = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic             in_bin,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_diff,
   output logic             out_bout,
   output logic             out_ovf,
   output logic             out_zero,
   output logic [TAG_W-1:0] out_tag
);

   if (WIDTH != ks_pkg::WIDTH || LEVELS != 4) begin : g_width_chk
      $error("ks16_pipe_subtractor: WIDTH must be 16 (four prefix levels)");
   end

   logic             vld_p1, vld_p2, vld_p3;
   logic             adv_1, adv_2, adv_3;

   logic [WIDTH-1:0] b_n;
   logic             c0;
   gp_t              leaf [WIDTH];
   gp_t              l0   [WIDTH];
   gp_t              l1   [WIDTH];
   gp_t              l2   [WIDTH];
   gp_t              l3   [WIDTH];
   gp_t              l4   [WIDTH];
   logic [WIDTH-1:0] p_l4_unused;

   gp_t              gp_p1 [WIDTH];
   logic [WIDTH-1:0] p_p1;
   logic             c0_p1;
   logic [TAG_W-1:0] tag_p1;

   logic [WIDTH-1:0] c_p2;
   logic [WIDTH-1:0] p_p2;
   logic             c0_p2;
   logic [TAG_W-1:0] tag_p2;

   logic [WIDTH-1:0] diff_s3;

   // Bubble-collapsing advance chain: an empty stage always accepts.
   assign adv_3     = ~vld_p3 | out_ready;
   assign adv_2     = ~vld_p2 | adv_3;
   assign adv_1     = ~vld_p1 | adv_2;
   assign in_ready  = rst_n & adv_1;
   assign out_valid = vld_p3;

   assign b_n = ~in_b;
   assign c0  = ~in_bin;

   for (genvar i = 0; i < WIDTH; i++) begin : g_leaf
      assign leaf[i] = ks_leaf(in_a[i], b_n[i]);
      if (i == 0) begin : g_fold
         // Column 0 absorbs the carry-in, so every prefix G is a true carry.
         assign l0[i] = '{g: leaf[i].g | (leaf[i].p & c0), p: 1'b0};
      end else begin : g_pass
         assign l0[i] = leaf[i];
      end
   end

   for (genvar i = 0; i < WIDTH; i++) begin : g_lvl1
      if (i >= 1) begin : g_node
         ks_prefix_cell u_cell (
            .Gh(l0[i].g), .Ph(l0[i].p), .Gl(l0[i-1].g), .Pl(l0[i-1].p),
            .G(l1[i].g), .P(l1[i].p)
         );
      end else begin : g_wire
         assign l1[i] = l0[i];
      end
   end

   for (genvar i = 0; i < WIDTH; i++) begin : g_lvl2
      if (i >= 2) begin : g_node
         ks_prefix_cell u_cell (
            .Gh(l1[i].g), .Ph(l1[i].p), .Gl(l1[i-2].g), .Pl(l1[i-2].p),
            .G(l2[i].g), .P(l2[i].p)
         );
      end else begin : g_wire
         assign l2[i] = l1[i];
      end
   end

   for (genvar i = 0; i < WIDTH; i++) begin : g_lvl3
      if (i >= 4) begin : g_node
         ks_prefix_cell u_cell (
            .Gh(gp_p1[i].g), .Ph(gp_p1[i].p), .Gl(gp_p1[i-4].g), .Pl(gp_p1[i-4].p),
            .G(l3[i].g), .P(l3[i].p)
         );
      end else begin : g_wire
         assign l3[i] = gp_p1[i];
      end
   end

   for (genvar i = 0; i < WIDTH; i++) begin : g_lvl4
      if (i >= 8) begin : g_node
         ks_prefix_cell u_cell (
            .Gh(l3[i].g), .Ph(l3[i].p), .Gl(l3[i-8].g), .Pl(l3[i-8].p),
            .G(l4[i].g), .P(l4[i].p)
         );
      end else begin : g_wire
         assign l4[i] = l3[i];
      end
      // Group propagate is meaningless once every column spans down to bit 0.
      assign p_l4_unused[i] = l4[i].p;
   end

   assign diff_s3 = p_p2 ^ {c_p2[WIDTH-2:0], c0_p2};

   // Control and output registers: cleared asynchronously.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_p1   <= 1'b0;
         vld_p2   <= 1'b0;
         vld_p3   <= 1'b0;
         out_diff <= '0;
         out_bout <= 1'b0;
         out_ovf  <= 1'b0;
         out_zero <= 1'b0;
         out_tag  <= '0;
      end else begin
         if (adv_1) vld_p1 <= in_valid;
         if (adv_2) vld_p2 <= vld_p1;
         if (adv_3) begin
            vld_p3 <= vld_p2;
            if (vld_p2) begin
               out_diff <= diff_s3;
               out_bout <= ~c_p2[WIDTH-1];
               out_ovf  <= c_p2[WIDTH-1] ^ c_p2[WIDTH-2];
               out_zero <= (diff_s3 == '0);
               out_tag  <= tag_p2;
            end
         end
      end
   end

   // Stage 1 / stage 2 datapath: loaded only on a transfer into the stage.
   always_ff @(posedge clk) begin
      if (adv_1 && in_valid) begin
         for (int i = 0; i < WIDTH; i++) begin
            gp_p1[i] <= l2[i];
            p_p1[i]  <= leaf[i].p;
         end
         c0_p1  <= c0;
         tag_p1 <= in_tag;
      end
      if (adv_2 && vld_p1) begin
         for (int i = 0; i < WIDTH; i++) c_p2[i] <= l4[i].g;
         p_p2   <= p_p1;
         c0_p2  <= c0_p1;
         tag_p2 <= tag_p1;
      end
   end

endmodule

// File: tb/tb_ks16_pipe_subtractor.sv
// Bench for ks16_pipe_subtractor: directed vector table, backpressure and
// reset sequences, and a randomised stream checked through a scoreboard.
module tb_ks16_pipe_subtractor;

   typedef struct packed {
      logic [15:0] diff;
      logic        bout;
      logic        ovf;
      logic        zero;
      logic [3:0]  tag;
   } res_t;

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic        bin;
      logic [3:0]  tag;
      res_t        exp;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [15:0] in_a = '0;
   logic [15:0] in_b = '0;
   logic        in_bin = 1'b0;
   logic [3:0]  in_tag = '0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [15:0] out_diff;
   logic        out_bout;
   logic        out_ovf;
   logic        out_zero;
   logic [3:0]  out_tag;

   int   n_checks = 0;
   int   n_fail = 0;
   res_t sb [$];
   bit   rand_mode = 1'b0;
   vec_t tbl [8];

   ks16_pipe_subtractor #(.WIDTH(16), .TAG_W(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_a(in_a), .in_b(in_b), .in_bin(in_bin), .in_tag(in_tag),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_diff(out_diff), .out_bout(out_bout), .out_ovf(out_ovf),
      .out_zero(out_zero), .out_tag(out_tag)
   );

   always #5 clk = ~clk;

   function automatic res_t model(input logic [15:0] a, input logic [15:0] b,
                                  input logic bin, input logic [3:0] tag);
      res_t        r;
      logic [16:0] w;
      int          sd;
      w  = {1'b0, a} - {1'b0, b} - 17'(bin);
      sd = int'($signed(a)) - int'($signed(b)) - int'(bin);
      r.diff = w[15:0];
      r.bout = w[16];
      r.ovf  = (sd > 32767) || (sd < -32768);
      r.zero = (w[15:0] == 16'h0000);
      r.tag  = tag;
      return r;
   endfunction

   function automatic vec_t mk(input logic [15:0] a, input logic [15:0] b, input logic bin,
                               input logic [3:0] tag, input logic [15:0] d, input logic bo,
                               input logic ov, input logic z);
      vec_t v;
      v.a = a; v.b = b; v.bin = bin; v.tag = tag;
      v.exp = '{diff: d, bout: bo, ovf: ov, zero: z, tag: tag};
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Drive one beat; the expected result is queued the cycle it is accepted.
   task automatic send(input logic [15:0] a, input logic [15:0] b, input logic bin,
                       input logic [3:0] tag, input res_t exp);
      int  w = 0;
      bit  done = 1'b0;
      in_a = a; in_b = b; in_bin = bin; in_tag = tag; in_valid = 1'b1;
      while (!done) begin
         @(negedge clk);
         if (in_ready) begin
            sb.push_back(exp);
            done = 1'b1;
         end else if (w > 200) begin
            chk("send timeout", 32'd0, 32'd1);
            done = 1'b1;
         end
         w++;
         @(posedge clk);
      end
      #1 in_valid = 1'b0;
   endtask

   task automatic drain();
      int w = 0;
      while (sb.size() != 0 && w < 200) begin
         @(negedge clk);
         w++;
      end
      chk("drain pending", 32'(sb.size()), 32'd0);
   endtask

   task automatic latency_check();
      @(negedge clk); chk("latency c1 out_valid", 32'(out_valid), 32'd0);
      @(negedge clk); chk("latency c2 out_valid", 32'(out_valid), 32'd0);
      @(negedge clk); chk("latency c3 out_valid", 32'(out_valid), 32'd1);
   endtask

   // Output monitor: scoreboard pop on each transfer, stability while stalled.
   initial begin
      res_t prev;
      res_t got;
      bit   hold_prev = 1'b0;
      forever begin
         @(negedge clk);
         if (rst_n) begin
            got = '{diff: out_diff, bout: out_bout, ovf: out_ovf, zero: out_zero, tag: out_tag};
            if (hold_prev) begin
               chk("stall out_valid held", 32'(out_valid), 32'd1);
               chk("stall outputs held", 32'(got), 32'(prev));
            end
            hold_prev = out_valid && !out_ready;
            prev = got;
            if (out_valid && out_ready) begin
               if (sb.size() == 0) chk("unexpected result", 32'(got), 32'd0 - 32'd1);
               else chk("result", 32'(got), 32'(sb.pop_front()));
            end
         end else begin
            hold_prev = 1'b0;
         end
      end
   end

   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (rand_mode) out_ready = ($urandom_range(0, 3) != 0);
      end
   end

   initial begin
      res_t e;
      logic [15:0] ra, rb;
      logic        rbin;
      logic [3:0]  rtag;

      tbl[0] = mk(16'h1234, 16'h0234, 1'b0, 4'd3,  16'h1000, 1'b0, 1'b0, 1'b0);
      tbl[1] = mk(16'h0000, 16'h0001, 1'b0, 4'd1,  16'hFFFF, 1'b1, 1'b0, 1'b0);
      tbl[2] = mk(16'h0005, 16'h0004, 1'b1, 4'd2,  16'h0000, 1'b0, 1'b0, 1'b1);
      tbl[3] = mk(16'h8000, 16'h0001, 1'b0, 4'd4,  16'h7FFF, 1'b0, 1'b1, 1'b0);
      tbl[4] = mk(16'h7FFF, 16'hFFFF, 1'b0, 4'd5,  16'h8000, 1'b1, 1'b1, 1'b0);
      tbl[5] = mk(16'hFFFF, 16'hFFFF, 1'b1, 4'd6,  16'hFFFF, 1'b1, 1'b0, 1'b0);
      tbl[6] = mk(16'h0000, 16'h0000, 1'b1, 4'd7,  16'hFFFF, 1'b1, 1'b0, 1'b0);
      tbl[7] = mk(16'h8000, 16'h7FFF, 1'b1, 4'd15, 16'h0000, 1'b0, 1'b1, 1'b1);

      repeat (3) @(negedge clk);
      chk("reset out_valid", 32'(out_valid), 32'd0);
      chk("reset in_ready", 32'(in_ready), 32'd0);
      chk("reset outputs", 32'({out_diff, out_bout, out_ovf, out_zero, out_tag}), 32'd0);
      @(posedge clk); #1 rst_n = 1'b1;
      @(posedge clk); #1;

      // Directed table, first entry also pins the latency.
      send(tbl[0].a, tbl[0].b, tbl[0].bin, tbl[0].tag, tbl[0].exp);
      latency_check();
      @(posedge clk); #1;
      for (int i = 1; i < 8; i++) send(tbl[i].a, tbl[i].b, tbl[i].bin, tbl[i].tag, tbl[i].exp);
      drain();

      // Backpressure: three beats fill the pipe, the fourth waits for out_ready.
      @(posedge clk); #1 out_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         ra = 16'($urandom); rb = 16'($urandom);
         send(ra, rb, 1'b0, 4'(k), model(ra, rb, 1'b0, 4'(k)));
      end
      ra = 16'($urandom); rb = 16'($urandom);
      fork
         send(ra, rb, 1'b1, 4'd3, model(ra, rb, 1'b1, 4'd3));
         begin
            @(negedge clk);
            chk("full in_ready", 32'(in_ready), 32'd0);
            chk("full out_valid", 32'(out_valid), 32'd1);
            chk("full out_tag", 32'(out_tag), 32'd0);
            repeat (3) begin
               @(negedge clk);
               chk("stalled out_tag", 32'(out_tag), 32'd0);
               chk("stalled in_ready", 32'(in_ready), 32'd0);
            end
            @(posedge clk); #2 out_ready = 1'b1;
            #1 chk("in_ready follows out_ready", 32'(in_ready), 32'd1);
         end
      join
      for (int k = 4; k < 6; k++) begin
         ra = 16'($urandom); rb = 16'($urandom);
         send(ra, rb, 1'b0, 4'(k), model(ra, rb, 1'b0, 4'(k)));
      end
      drain();

      // Reset while two operations are in flight.
      @(posedge clk); #1 out_ready = 1'b0;
      send(16'h00F0, 16'h000F, 1'b0, 4'd9, model(16'h00F0, 16'h000F, 1'b0, 4'd9));
      send(16'h1111, 16'h2222, 1'b1, 4'd10, model(16'h1111, 16'h2222, 1'b1, 4'd10));
      repeat (2) @(negedge clk);
      chk("pre-reset out_valid", 32'(out_valid), 32'd1);
      #2 rst_n = 1'b0;
      #1 chk("async reset out_valid", 32'(out_valid), 32'd0);
      chk("async reset in_ready", 32'(in_ready), 32'd0);
      sb.delete();
      out_ready = 1'b1;
      @(negedge clk); #2 rst_n = 1'b1;
      repeat (4) begin
         @(negedge clk);
         chk("post-reset no stale", 32'(out_valid), 32'd0);
      end
      @(posedge clk); #1;
      send(16'hABCD, 16'h0BCD, 1'b0, 4'd11, model(16'hABCD, 16'h0BCD, 1'b0, 4'd11));
      latency_check();
      drain();

      // Randomised stream with random gaps and random backpressure.
      @(posedge clk); #1 rand_mode = 1'b1;
      for (int n = 0; n < 10000; n++) begin
         ra = 16'($urandom); rb = 16'($urandom);
         rbin = 1'($urandom); rtag = 4'($urandom);
         e = model(ra, rb, rbin, rtag);
         send(ra, rb, rbin, rtag, e);
         repeat ($urandom_range(0, 1)) begin
            @(posedge clk); #1;
         end
      end
      rand_mode = 1'b0;
      @(posedge clk); #2 out_ready = 1'b1;
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
